// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: push handshake carrying {note, octave, duration} entries into tone_sequencer.
//   in_valid   source offers an entry
//   in_ready   sink can accept an entry
//   in_note    0 or 13..15 = rest, 1..12 = C..B
//   in_octave  frequency multiplier 2^in_octave
//   in_dur     note length in duration ticks
interface tone_sequencer_if #(
    parameter int DUR_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_note;
    logic [1:0]       in_octave;
    logic [DUR_W-1:0] in_dur;
    modport master (output in_valid, in_note, in_octave, in_dur, input in_ready);
    modport slave  (input in_valid, in_note, in_octave, in_dur, output in_ready);
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: queued piezo tone player; plays FIFO'd {note, octave, dur} entries as square waves.
//   clk, rst      clock, synchronous active-high reset
//   in_if         push handshake (slave side of tone_sequencer_if)
//   play          1 = run, 0 = pause (counters freeze, buzz low)
//   flush         drop current note and empty the FIFO
//   buzz          square-wave output
//   busy          a note is loaded (LOAD/PLAY/GAP)
//   note_done     one-cycle pulse when an entry finishes
//   fifo_count    queued entries
// Optional: define TONE_GAP_EN to insert GAP_TICKS silent ticks after every completed note.
module tone_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int DUR_W      = 12,
    parameter int DIV_W      = 26,
    parameter int GAP_TICKS  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    tone_sequencer_if.slave             in_if,
    input  logic                        play,
    input  logic                        flush,
    output logic                        buzz,
    output logic                        busy,
    output logic                        note_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW       = DUR_W + 6;
    // Octave-0 half periods indexed by note code; rest codes hold a dummy 1.
    localparam int BASE_HP [16] = '{1,
        CLK_HZ / 524, CLK_HZ / 554, CLK_HZ / 588, CLK_HZ / 622, CLK_HZ / 660, CLK_HZ / 698,
        CLK_HZ / 740, CLK_HZ / 784, CLK_HZ / 830, CLK_HZ / 880, CLK_HZ / 932, CLK_HZ / 988,
        1, 1, 1};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    state_t           st_q, st_d;
    logic [DIV_W-1:0] hp_q, hp_d, tone_q, tone_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [DUR_W-1:0] left_q, left_d;
    logic             rest_q, rest_d, buzz_q, buzz_d, done_q, done_d;
    logic             push, pop, run, tick, wrap;
    logic [EW-1:0]    head;
    logic [3:0]       head_note;
    logic [1:0]       head_oct;
    int               hp_raw;

    assign in_if.in_ready = !rst && cnt_q != (AW+1)'(FIFO_DEPTH);
    // Flush wins over a same-cycle push and blocks popping.
    assign push      = in_if.in_valid && in_if.in_ready && !flush;
    assign pop       = st_q == IDLE && play && cnt_q != '0 && !flush;
    assign head      = mem_q[rd_q];
    assign head_note = head[EW-1 -: 4];
    assign head_oct  = head[DUR_W +: 2];
    assign hp_raw    = BASE_HP[head_note] >> head_oct;
    assign run       = play && (st_q == PLAY || st_q == GAP);
    assign tick      = run && pre_q == PW'(TICK_DIV - 1);
    assign wrap      = tone_q == hp_q - DIV_W'(1);

    assign buzz       = buzz_q && play;
    assign busy       = st_q != IDLE;
    assign note_done  = done_q;
    assign fifo_count = cnt_q;

    always_comb begin
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        st_d   = st_q;
        hp_d   = hp_q;
        rest_d = rest_q;
        left_d = left_q;
        tone_d = tone_q;
        pre_d  = run ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
        buzz_d = buzz_q;
        done_d = 1'b0;
        case (st_q)
            IDLE: if (pop) begin
                st_d   = LOAD;
                hp_d   = (hp_raw == 0) ? DIV_W'(1) : DIV_W'(hp_raw);
                rest_d = head_note == 4'd0 || head_note > 4'd12;
                left_d = head[DUR_W-1:0];
            end
            LOAD: begin
                tone_d = '0;
                pre_d  = '0;
                buzz_d = 1'b0;
                done_d = left_q == '0;
                st_d   = (left_q == '0) ? IDLE : PLAY;
            end
            PLAY: if (play) begin
                tone_d = wrap ? '0 : tone_q + DIV_W'(1);
                buzz_d = wrap ? !buzz_q && !rest_q : buzz_q;
                if (tick) begin
                    left_d = left_q - DUR_W'(1);
                    if (left_q == DUR_W'(1)) begin
                        buzz_d = 1'b0;
                        done_d = 1'b1;
`ifdef TONE_GAP_EN
                        st_d   = (GAP_TICKS > 0) ? GAP : IDLE;
                        left_d = DUR_W'(GAP_TICKS);
`else
                        st_d   = IDLE;
`endif
                    end
                end
            end
`ifdef TONE_GAP_EN
            GAP: if (tick) begin
                left_d = left_q - DUR_W'(1);
                st_d   = (left_q == DUR_W'(1)) ? IDLE : GAP;
            end
`endif
            default: ;
        endcase
        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            st_d   = IDLE;
            buzz_d = 1'b0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_if.in_note, in_if.in_octave, in_if.in_dur};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            st_q   <= IDLE;
            hp_q   <= DIV_W'(1);
            rest_q <= 1'b0;
            left_q <= '0;
            tone_q <= '0;
            pre_q  <= '0;
            buzz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            hp_q   <= hp_d;
            rest_q <= rest_d;
            left_q <= left_d;
            tone_q <= tone_d;
            pre_q  <= pre_d;
            buzz_q <= buzz_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: randomized self-checking bench for tone_sequencer against a pitch/timing model.
module tb_tone_sequencer;
    localparam int CLK_HZ = 1_000_000;
    localparam int TICK_HZ = 1000;
    localparam int TD = CLK_HZ / TICK_HZ;
    localparam int DEPTH = 4;
    localparam int DUR_W = 12;
    localparam int DIV_W = 26;
    localparam int GAP_TICKS = 2;

    logic clk = 1'b0;
    logic rst, play, flush, buzz, busy, note_done;
    logic [2:0] fifo_count;
    int checks = 0;
    int fails = 0;
    int freq [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    tone_sequencer_if #(.DUR_W(DUR_W)) bus ();

    tone_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FIFO_DEPTH(DEPTH),
        .DUR_W(DUR_W), .DIV_W(DIV_W), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .in_if(bus), .play(play), .flush(flush),
        .buzz(buzz), .busy(busy), .note_done(note_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, fails=%0d", fails);
        $fatal(1, "timeout");
    end

    // Half period from the frequency table; 0 means rest.
    function automatic int exp_hp(input int note, input int oct);
        int hp;
        if (note < 1 || note > 12) return 0;
        hp = (CLK_HZ / (2 * freq[note-1])) >> oct;
        return (hp < 1) ? 1 : hp;
    endfunction

    task automatic push(input int note, input int oct, input int dur);
        bus.in_valid = 1'b1;
        bus.in_note = 4'(note);
        bus.in_octave = 2'(oct);
        bus.in_dur = DUR_W'(dur);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 10000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    // Plays one entry from an empty FIFO with play=1 and checks the whole waveform.
    task automatic run_note(input int note, input int oct, input int dur,
                            input int pause_at, input int pause_len, output int rise);
        int hp, eb, bad, first_bad, w;
        hp = exp_hp(note, oct);
        rise = -1;
        bad = 0;
        first_bad = -1;
        push(note, oct, dur);
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (busy !== 1'b1 || buzz !== 1'b0 || note_done !== 1'b0) begin
            fails++;
            $display("FAIL load_state: busy=%b buzz=%b done=%b required 1 0 0", busy, buzz, note_done);
        end
        for (int t = 0; t < dur * TD; t++) begin
            @(negedge clk);
            eb = (hp == 0) ? 0 : (t / hp) % 2;
            if (buzz !== 1'(eb) || busy !== 1'b1 || note_done !== 1'b0) begin
                if (first_bad < 0) first_bad = t;
                bad++;
            end
            if (buzz === 1'b1 && rise < 0) rise = t;
            if (t == pause_at - 1) begin
                play = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    @(negedge clk);
                    if (buzz !== 1'b0 || busy !== 1'b1 || note_done !== 1'b0) begin
                        if (first_bad < 0) first_bad = t;
                        bad++;
                    end
                end
                play = 1'b1;
            end
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL waveform note=%0d oct=%0d dur=%0d: %0d bad cycles, first at t=%0d, required 0",
                     note, oct, dur, bad, first_bad);
        end
        @(negedge clk);
        checks++;
        if (note_done !== 1'b1 || buzz !== 1'b0) begin
            fails++;
            $display("FAIL note_done_pulse: done=%b buzz=%b required 1 0", note_done, buzz);
        end
`ifdef TONE_GAP_EN
        bad = 0;
        for (int g = 1; g < GAP_TICKS * TD; g++) begin
            @(negedge clk);
            if (busy !== 1'b1 || buzz !== 1'b0 || note_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL gap: %0d bad gap cycles, required 0", bad);
        end
`endif
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || note_done !== 1'b0) begin
            fails++;
            $display("FAIL after_note: busy=%b done=%b required 0 0", busy, note_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        play = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (buzz !== 1'b0 || busy !== 1'b0 || note_done !== 1'b0 || fifo_count !== 3'd0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset: buzz=%b busy=%b done=%b count=%0d ready=%b required all 0",
                     buzz, busy, note_done, fifo_count, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL post_reset: ready=%b count=%0d required 1 0", bus.in_ready, fifo_count);
        end
    endtask

    task automatic test_pitch();
        int rise;
        run_note(10, 0, 3, 0, 0, rise);
        checks++;
        if (rise !== 1136) begin
            fails++;
            $display("FAIL a4_half_period: first rise t=%0d required 1136", rise);
        end
        run_note(10, 1, 1, 0, 0, rise);
        checks++;
        if (rise !== 568) begin
            fails++;
            $display("FAIL a5_half_period: first rise t=%0d required 568", rise);
        end
        run_note(0, 0, 2, 0, 0, rise);
        checks++;
        if (rise !== -1) begin
            fails++;
            $display("FAIL rest_silent: first rise t=%0d required -1", rise);
        end
    endtask

    task automatic test_random();
        int note, oct, dur, pat, plen, rise, hp, er;
        for (int i = 0; i < 6; i++) begin
            note = int'($urandom_range(0, 15));
            oct = int'($urandom_range(0, 3));
            dur = int'($urandom_range(1, 2));
            pat = int'($urandom_range(1, dur * TD - 1));
            plen = int'($urandom_range(0, 40));
            run_note(note, oct, dur, pat, plen, rise);
            hp = exp_hp(note, oct);
            er = (hp == 0 || hp >= dur * TD) ? -1 : hp;
            checks++;
            if (rise !== er) begin
                fails++;
                $display("FAIL random_rise note=%0d oct=%0d: t=%0d required %0d", note, oct, rise, er);
            end
        end
    endtask

    task automatic test_full();
        int dones = 0;
        play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.in_ready !== (i < 4)) begin
                fails++;
                $display("FAIL in_ready_push%0d: ready=%b required %0d", i, bus.in_ready, i < 4);
            end
            push(1, 3, 1);
        end
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full: count=%0d ready=%b busy=%b required 4 0 0", fifo_count, bus.in_ready, busy);
        end
        play = 1'b1;
        for (int c = 0; c < 13000; c++) begin
            @(negedge clk);
            if (note_done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 4 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_drain: dones=%0d count=%0d busy=%b required 4 0 0", dones, fifo_count, busy);
        end
    endtask

    task automatic test_zero_dur();
        int d1 = -1, d2 = -1, nd = 0, rise = -1;
        logic b2 = 1'bx, b3 = 1'bx;
        play = 1'b0;
        push(5, 0, 0);
        push(1, 3, 1);
        play = 1'b1;
        for (int s = 1; s <= 1010; s++) begin
            @(negedge clk);
            if (note_done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = s;
                else d2 = s;
            end
            if (s == 2) b2 = busy;
            if (s == 3) b3 = busy;
            if (buzz === 1'b1 && rise < 0) rise = s;
        end
        checks++;
        if (d1 !== 2 || b2 !== 1'b0 || b3 !== 1'b1) begin
            fails++;
            $display("FAIL zero_dur: done at %0d busy@2=%b busy@3=%b required 2 0 1", d1, b2, b3);
        end
        checks++;
        if (rise !== 4 + exp_hp(1, 3) || d2 !== 4 + TD || nd !== 2) begin
            fails++;
            $display("FAIL after_zero_dur: rise=%0d done2=%0d n=%0d required %0d %0d 2",
                     rise, d2, nd, 4 + exp_hp(1, 3), 4 + TD);
        end
        wait_idle();
    endtask

    task automatic test_pause();
        int rise;
        run_note(10, 0, 2, 1300, 500, rise);
        checks++;
        if (rise !== 1136) begin
            fails++;
            $display("FAIL pause_rise: t=%0d required 1136", rise);
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        play = 1'b0;
        push(10, 0, 3);
        push(1, 0, 1);
        play = 1'b1;
        repeat (500) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL pre_flush: busy=%b count=%0d required 1 1", busy, fifo_count);
        end
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_note = 4'd3;
        bus.in_dur = DUR_W'(1);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (buzz !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || note_done !== 1'b0) begin
            fails++;
            $display("FAIL flush: buzz=%b count=%0d busy=%b done=%b required 0 0 0 0",
                     buzz, fifo_count, busy, note_done);
        end
        for (int c = 0; c < 3100; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || note_done !== 1'b0 || buzz !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL post_flush_quiet: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_rst_mid();
        play = 1'b0;
        push(8, 1, 3);
        push(2, 0, 2);
        play = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || buzz !== 1'b0 || fifo_count !== 3'd0 || bus.in_ready !== 1'b0 || note_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: busy=%b buzz=%b count=%0d ready=%b done=%b required all 0",
                     busy, buzz, fifo_count, bus.in_ready, note_done);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL after_rst_mid: busy=%b count=%0d ready=%b required 0 0 1", busy, fifo_count, bus.in_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        play = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_note = '0;
        bus.in_octave = '0;
        bus.in_dur = '0;
        test_reset();
        play = 1'b1;
        test_pitch();
        test_random();
        test_full();
        test_zero_dur();
        test_pause();
        test_flush();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
